// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the program counter, drives the instruction
// memory read address and registers the returned word into the IF/ID
// pipeline register. Handles jalr/branch redirects, decode stalls and
// misaligned-target faults (fetch halts until reset).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   stall               decode not ready: hold PC and IF/ID
//   branch_taken/target branch redirect
//   jump_valid/target   jalr redirect (bit0 cleared here), wins over branch
//   address             current PC, instruction memory read address
//   instruction         combinational read data from instruction memory
//   if_id_pc/_pc_plus4  PC and link value of the registered instruction
//   if_id_instr/_valid  registered instruction and its valid flag
//   fetch_fault         sticky misaligned-target flag
module instruction_fetch_unit #(
    parameter int unsigned            INS_ADDRESS = 32,
    parameter int unsigned            INS_W       = 32,
    parameter logic [INS_ADDRESS-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall,
    input  logic                   branch_taken,
    input  logic [INS_ADDRESS-1:0] branch_target,
    input  logic                   jump_valid,
    input  logic [INS_ADDRESS-1:0] jump_target,
    output logic [INS_ADDRESS-1:0] address,
    input  logic [INS_W-1:0]       instruction,
    output logic [INS_ADDRESS-1:0] if_id_pc,
    output logic [INS_ADDRESS-1:0] if_id_pc_plus4,
    output logic [INS_W-1:0]       if_id_instr,
    output logic                   if_id_valid,
    output logic                   fetch_fault
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [INS_ADDRESS-1:0] pc_q, pc_d;
    logic [INS_ADDRESS-1:0] pc_plus4;
    logic                   valid_d;
    logic                   ifid_load;

    logic                   redirect;
    logic [INS_ADDRESS-1:0] target;
    logic                   misaligned;

    assign pc_plus4   = pc_q + INS_ADDRESS'(4);
    assign redirect   = jump_valid | branch_taken;
    // jalr target has bit0 cleared before the alignment check
    assign target     = jump_valid ? (jump_target & ~INS_ADDRESS'(1)) : branch_target;
    assign misaligned = (target[1:0] != 2'b00);

    assign address     = pc_q;
    // The fault flag is sticky by construction: FAULT is only left via reset
    assign fetch_fault = (state_q == FAULT);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT: begin
                if (!stall) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (redirect && misaligned) begin
                    state_d = FAULT;
                end
            end
            FAULT:   state_d = FAULT;
            default: state_d = BOOT;
        endcase
    end

    // Output / datapath control: next PC, IF/ID capture and valid
    always_comb begin
        pc_d      = pc_q;
        valid_d   = if_id_valid;
        ifid_load = 1'b0;
        case (state_q)
            BOOT: begin
                // Redirects are not meaningful before the first fetch
                if (!stall) begin
                    pc_d      = pc_plus4;
                    valid_d   = 1'b1;
                    ifid_load = 1'b1;
                end
            end
            RUN: begin
                if (redirect) begin
                    // Redirect overrides stall; flush the wrong-path word
                    valid_d = 1'b0;
                    if (!misaligned) begin
                        pc_d = target;
                    end
                end else if (!stall) begin
                    pc_d      = pc_plus4;
                    valid_d   = 1'b1;
                    ifid_load = 1'b1;
                end
            end
            FAULT: begin
                valid_d = 1'b0;
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    // PC and IF/ID pipeline register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q           <= RESET_PC;
            if_id_pc       <= '0;
            if_id_pc_plus4 <= '0;
            if_id_instr    <= '0;
            if_id_valid    <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            if_id_valid <= valid_d;
            if (ifid_load) begin
                if_id_pc       <= pc_q;
                if_id_pc_plus4 <= pc_plus4;
                if_id_instr    <= instruction;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump_valid;
    logic [31:0] jump_target;
    logic [31:0] address;
    logic [31:0] instruction;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        fetch_fault;

    // Second instance starting near the top of the address space
    logic [31:0] w_address;
    logic [31:0] w_instruction;
    logic [31:0] w_if_id_pc;
    logic [31:0] w_if_id_pc_plus4;
    logic [31:0] w_if_id_instr;
    logic        w_if_id_valid;
    logic        w_fetch_fault;

    int unsigned n_vec;
    int unsigned n_err;

    // Instruction memory contents as a pure function of the address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0)
            return 32'h00200093;
        else if (a == 32'h4)
            return 32'h00100113;
        else if (a < 32'h80)
            return 32'h10000000 | {27'd0, a[6:2]};
        else
            return ~a;
    endfunction

    assign instruction   = mem_word(address);
    assign w_instruction = mem_word(w_address);

    instruction_fetch_unit #(
        .INS_ADDRESS(32),
        .INS_W(32),
        .RESET_PC(32'h0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .stall(stall),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .jump_valid(jump_valid),
        .jump_target(jump_target),
        .address(address),
        .instruction(instruction),
        .if_id_pc(if_id_pc),
        .if_id_pc_plus4(if_id_pc_plus4),
        .if_id_instr(if_id_instr),
        .if_id_valid(if_id_valid),
        .fetch_fault(fetch_fault)
    );

    instruction_fetch_unit #(
        .INS_ADDRESS(32),
        .INS_W(32),
        .RESET_PC(32'hFFFFFFF8)
    ) dut_wrap (
        .clk(clk),
        .rst_n(rst_n),
        .stall(1'b0),
        .branch_taken(1'b0),
        .branch_target(32'h0),
        .jump_valid(1'b0),
        .jump_target(32'h0),
        .address(w_address),
        .instruction(w_instruction),
        .if_id_pc(w_if_id_pc),
        .if_id_pc_plus4(w_if_id_pc_plus4),
        .if_id_instr(w_if_id_instr),
        .if_id_valid(w_if_id_valid),
        .fetch_fault(w_fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s [%0d]: got 0x%08h, expected 0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic check_main(input int idx, input logic [31:0] e_addr,
                              input logic [31:0] e_pc, input logic [31:0] e_pc4,
                              input logic [31:0] e_instr, input logic e_valid,
                              input logic e_fault);
        check("address", idx, address, e_addr);
        check("if_id_pc", idx, if_id_pc, e_pc);
        check("if_id_pc_plus4", idx, if_id_pc_plus4, e_pc4);
        check("if_id_instr", idx, if_id_instr, e_instr);
        check("if_id_valid", idx, {31'd0, if_id_valid}, {31'd0, e_valid});
        check("fetch_fault", idx, {31'd0, fetch_fault}, {31'd0, e_fault});
    endtask

    task automatic check_wrap(input int idx, input logic [31:0] e_addr,
                              input logic [31:0] e_pc, input logic [31:0] e_pc4,
                              input logic [31:0] e_instr, input logic e_valid);
        check("wrap_address", idx, w_address, e_addr);
        check("wrap_if_id_pc", idx, w_if_id_pc, e_pc);
        check("wrap_if_id_pc_plus4", idx, w_if_id_pc_plus4, e_pc4);
        check("wrap_if_id_instr", idx, w_if_id_instr, e_instr);
        check("wrap_if_id_valid", idx, {31'd0, w_if_id_valid}, {31'd0, e_valid});
        check("wrap_fetch_fault", idx, {31'd0, w_fetch_fault}, 32'd0);
    endtask

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] bt;
        logic        jv;
        logic [31:0] jt;
        logic [31:0] e_addr;
        logic [31:0] e_pc;
        logic [31:0] e_pc4;
        logic [31:0] e_instr;
        logic        e_valid;
        logic        e_fault;
    } vec_t;

    vec_t vecs[16];

    initial begin
        n_vec = 0;
        n_err = 0;

        //           stall br  bt          jv  jt           addr         pc           pc4          instr          v     f
        vecs[0]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  32'h04, 32'h00, 32'h04, 32'h00200093, 1'b1, 1'b0}; // boot fetch
        vecs[1]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  32'h08, 32'h04, 32'h08, 32'h00100113, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  32'h08, 32'h04, 32'h08, 32'h00100113, 1'b1, 1'b0}; // stall x3
        vecs[3]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  32'h08, 32'h04, 32'h08, 32'h00100113, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  32'h08, 32'h04, 32'h08, 32'h00100113, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  32'h0C, 32'h08, 32'h0C, 32'h10000002, 1'b1, 1'b0}; // release
        vecs[6]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h19, 32'h18, 32'h08, 32'h0C, 32'h10000002, 1'b0, 1'b0}; // jalr, bit0 cleared
        vecs[7]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  32'h1C, 32'h18, 32'h1C, 32'h10000006, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 32'h20, 1'b1, 32'h40, 32'h40, 32'h18, 32'h1C, 32'h10000006, 1'b0, 1'b0}; // jump wins, beats stall
        vecs[9]  = '{1'b0, 1'b1, 32'h20, 1'b0, 32'h0,  32'h20, 32'h18, 32'h1C, 32'h10000006, 1'b0, 1'b0}; // back-to-back
        vecs[10] = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  32'h20, 32'h18, 32'h1C, 32'h10000006, 1'b0, 1'b0}; // stall keeps valid=0
        vecs[11] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  32'h24, 32'h20, 32'h24, 32'h10000008, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  32'h28, 32'h24, 32'h28, 32'h10000009, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 32'h06, 1'b0, 32'h0,  32'h28, 32'h24, 32'h28, 32'h10000009, 1'b0, 1'b1}; // misaligned
        vecs[14] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  32'h28, 32'h24, 32'h28, 32'h10000009, 1'b0, 1'b1}; // frozen
        vecs[15] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h40, 32'h28, 32'h24, 32'h28, 32'h10000009, 1'b0, 1'b1};

        rst_n         = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        jump_valid    = 1'b0;
        jump_target   = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        check_main(-1, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("wrap_reset_address", -1, w_address, 32'hFFFFFFF8);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            stall         = vecs[i].stall;
            branch_taken  = vecs[i].br;
            branch_target = vecs[i].bt;
            jump_valid    = vecs[i].jv;
            jump_target   = vecs[i].jt;
            @(posedge clk);
            #1;
            check_main(i, vecs[i].e_addr, vecs[i].e_pc, vecs[i].e_pc4,
                       vecs[i].e_instr, vecs[i].e_valid, vecs[i].e_fault);
        end

        // Mid-cycle reset pulse: outputs must clear without a clock edge
        stall         = 1'b0;
        branch_taken  = 1'b0;
        jump_valid    = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_main(100, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("wrap_async_reset_address", 100, w_address, 32'hFFFFFFF8);
        #1;
        rst_n = 1'b1;

        // Restart from RESET_PC; wrap instance crosses 0xFFFFFFFC -> 0
        @(posedge clk);
        #1;
        check_main(101, 32'h04, 32'h00, 32'h04, 32'h00200093, 1'b1, 1'b0);
        check_wrap(101, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'hFFFFFFFC, 32'h00000007, 1'b1);
        @(posedge clk);
        #1;
        check_wrap(102, 32'h00000000, 32'hFFFFFFFC, 32'h00000000, 32'h00000003, 1'b1);
        @(posedge clk);
        #1;
        check_wrap(103, 32'h00000004, 32'h00000000, 32'h00000004, 32'h00200093, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
